num: RTL
========

# num

Iterative MIX NUM (command 5(0)) unit: converts the ten 6-bit character bytes of rAX into a 30-bit binary magnitude, processing one byte per clock from most to least significant. Each byte contributes its value mod 10, so MIX digit codes 30–39 map to digits 0–9. This is the inverse companion of the CHAR stage: it consumes the 60-bit character word that CHAR produces. The result goes to rA; rA and rX signs are handled outside this block.

## Interface
Parameters:
- none (widths fixed by the MIX word format: 5 bytes × 6 bits per register)

Ports:
- `clk` in 1: system clock; all state changes on the rising edge
- `reset` in 1: synchronous, active-high reset
- `start` in 1: single-cycle request; samples `in` on this edge
- `in` in 60: character word {rA[29:0], rX[29:0]}; byte 0 = `in[59:54]` (most significant digit), byte 9 = `in[5:0]`
- `stop` out 1: registered one-cycle pulse; `out`/`ovf` valid from this cycle on
- `out` out 30: binary result mod 2^30; held until the next completion
- `ovf` out 1: set when the true value exceeds 2^30−1; held with `out`

## Operation
- Internal state: `run`, 4-bit counter `cnt`, 60-bit shift register `sh`, 30-bit accumulator `acc`, sticky overflow `ov`.
- Digit function: d(b) = b mod 10 for a 6-bit byte b (0..63), giving 0..9. Examples: 0→0, 30→0, 39→9, 45→5, 63→3.
- Step: t = acc·10 + d(sh[59:54]), computed as (acc<<3)+(acc<<1)+d at ≥34 bits. acc ← t[29:0]. ov ← ov | (t[33:30] ≠ 0). sh ← sh<<6.
- Because each step keeps only the low 30 bits, the final acc equals the true value mod 2^30. ov is set when any step's t ≥ 2^30, which happens iff the true 10-digit value is ≥ 2^30.
- States:
  - IDLE (run=0): nothing changes except on `start`.
  - RUN (run=1): one step per edge.
- Transitions:
  - start: sh←in, acc←0, ov←0, cnt←0, run←1. This happens from any state, so it aborts a conversion in progress with no `stop` for the aborted one.
  - RUN with cnt<9: step, then cnt←cnt+1.
  - RUN with cnt==9: final step. Then run←0, out←new acc, ovf←new ov, stop←1.
- `stop` is 0 on every other edge.
- `out`/`ovf` update only at completion. They never show partial values.
- Simultaneous `start` and final step: start wins, so reload happens and no `stop` is issued.
- `start` while IDLE with a `stop` pulse pending: the pulse still completes its single cycle.

## Timing
- Edge E0 samples `start`. Steps run at E1..E10. `stop` is high for the single cycle after E10, giving a latency of 10 cycles from start edge to stop.
- Throughput: a new `start` is legal at E10 or later. At E10 it overrides completion, per the rule above; issue it at E11 or later to keep the result.
- Reset values: `stop`=0, `out`=0, `ovf`=0, run=0, cnt=0, acc=0, sh=0, ov=0.
- `reset` mid-conversion: aborts, returns to IDLE and clears all outputs. No `stop` is issued.
- `reset` has priority over `start` on the same edge.
- `in` is not looked at except on the `start` edge, so the upstream may change it freely afterwards.

## Test plan
- Bytes 30,30,30,30,30,30,30,30,31,32 ("0000000012") with one start pulse. Required: stop exactly 10 cycles later, out=12, ovf=0, stop high for one cycle only.
- All bytes 39 ("9999999999"). Required: out=336323583 (9999999999 mod 2^30), ovf=1.
- Non-digit bytes 0,63,45,10,20,0,0,0,0,1. Digits are 0,3,5,0,0,0,0,0,0,1, so required out=350000001, ovf=0.
- Round trip: drive the CHAR encoding of 123456789 (bytes 30,31,32,33,34,35,36,37,38,39). Required: out=123456789, ovf=0. Also drive the encoding of 1073741823. Required: out=1073741823, ovf=0.
- Restart: start with all-39, then start again 4 cycles later with "0000000007". Required: a single stop, 10 cycles after the second start, with out=7 and ovf=0.
- Reset: reset asserted 5 cycles into a conversion. Required: no stop, out=0, ovf=0. A following start still completes normally.

Source files
------------

// File: rtl/num_if.sv
// num_if: start/operand request and stop/result completion signals of the NUM unit.
interface num_if;
  logic        start;
  logic [59:0] in;
  logic        stop;
  logic [29:0] out;
  logic        ovf;

  modport master (
    output start,
    output in,
    input  stop,
    input  out,
    input  ovf
  );

  modport slave (
    input  start,
    input  in,
    output stop,
    output out,
    output ovf
  );
endinterface

// File: rtl/num.sv
// num: iterative MIX NUM. Folds ten 6-bit character bytes, most significant first,
// into a 30-bit binary magnitude. Each byte contributes its value mod 10.
// A sticky flag records whether the true value needed more than 30 bits.
module num (
  input logic clk,
  input logic reset,
  num_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [59:0] sh_q, sh_d;
  logic [29:0] acc_q, acc_d;
  logic        ov_q, ov_d;
  logic        stop_q, stop_d;
  logic [29:0] out_q, out_d;
  logic        ovf_q, ovf_d;

  logic [3:0]  dig;
  logic [33:0] acc_w;
  logic [33:0] t;
  logic        last;
  logic        t_ovf;

  // One conversion step: t = acc*10 + digit of the leading byte, kept wide enough to see carry-out.
  always_comb begin
    dig   = 4'(sh_q[59:54] % 6'd10);
    acc_w = {4'd0, acc_q};
    t     = (acc_w << 3) + (acc_w << 1) + {30'd0, dig};
    t_ovf = |t[33:30];
    last  = (state_q == StRun) && (cnt_q == 4'd9);
  end

  // State and datapath registers; reset clears everything, including the visible result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      sh_q    <= 60'd0;
      acc_q   <= 30'd0;
      ov_q    <= 1'b0;
      stop_q  <= 1'b0;
      out_q   <= 30'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      ov_q    <= ov_d;
      stop_q  <= stop_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state: start always (re)launches a conversion, even over one in progress.
  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = StRun;
    end else if (last) begin
      state_d = StIdle;
    end
  end

  // Datapath next values: load on start, otherwise one step per cycle while running.
  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    acc_d = acc_q;
    ov_d  = ov_q;
    if (bus.start) begin
      cnt_d = 4'd0;
      sh_d  = bus.in;
      acc_d = 30'd0;
      ov_d  = 1'b0;
    end else if (state_q == StRun) begin
      cnt_d = last ? cnt_q : cnt_q + 4'd1;
      sh_d  = {sh_q[53:0], 6'd0};
      acc_d = t[29:0];
      ov_d  = ov_q | t_ovf;
    end
  end

  // Outputs: publish the result only on the final step, and only when not overridden by start.
  always_comb begin
    stop_d = last && !bus.start;
    out_d  = out_q;
    ovf_d  = ovf_q;
    if (stop_d) begin
      out_d = t[29:0];
      ovf_d = ov_q | t_ovf;
    end
  end

  assign bus.stop = stop_q;
  assign bus.out  = out_q;
  assign bus.ovf  = ovf_q;

endmodule
